cam_lane_align: RTL and testbench

CAM_LANE_ALIGN -- requirements
Module: cam_lane_align

---
 rtl/cam_lane_align.sv | 180 ++++++++++++++++++
 tb/tb_cam_lane_align.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_lane_align.sv
// Multi-camera deserialiser lane alignment: every lane hunts for the training word by
// issuing bitslips, then per-camera lock/fail status and a global busy flag are decoded.
module cam_lane_align #(
    parameter int                        NUM_CAMS    = 2,
    parameter int                        LANES       = 5,
    parameter int                        W           = 8,
    parameter logic [W-1:0]              TRAIN       = 8'h3A,
    parameter int                        MATCH_COUNT = 16,
    parameter int                        SLIP_WAIT   = 4,
    parameter logic [NUM_CAMS*LANES-1:0] INV_MASK    = '0
) (
    input  logic                        c,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_CAMS-1:0]         rx_locked,
    input  logic [NUM_CAMS*LANES*W-1:0] rxd,
    output logic [NUM_CAMS*LANES-1:0]   bitslip,
    output logic [NUM_CAMS*LANES*W-1:0] rxd_out,
    output logic [NUM_CAMS-1:0]         cam_locked,
    output logic [NUM_CAMS-1:0]         cam_fail,
    output logic                        busy
);
    localparam int NL = NUM_CAMS * LANES;
    localparam int WW = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);
    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int SW = $clog2(W + 1);

    localparam logic [WW-1:0] WAIT_LOAD  = WW'(SLIP_WAIT);
    localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);
    localparam logic [SW-1:0] SLIP_LAST  = SW'(W - 1);
    localparam logic [SW-1:0] SLIP_ONE   = SW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CHECK  = 3'd2,
        S_SLIP   = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } lane_state_t;

    logic [NL*W-1:0]     w_corr;
    logic [NL-1:0]       w_lane_locked;
    logic [NL-1:0]       w_lane_fail;
    logic [NL-1:0]       w_lane_busy;
    logic [NL-1:0]       w_lane_slip;
    logic [NUM_CAMS-1:0] w_cam_locked;
    logic [NUM_CAMS-1:0] w_cam_fail;

    logic [NL*W-1:0]     r_rxd_out;
    logic [NUM_CAMS-1:0] r_cam_locked;
    logic [NUM_CAMS-1:0] r_cam_fail;
    logic                r_busy;

    for (genvar gl = 0; gl < NL; gl++) begin : g_lane
        localparam int CAM = gl / LANES;

        lane_state_t   r_state;
        lane_state_t   w_next;
        logic [WW-1:0] r_wait;
        logic [WW-1:0] w_wait_nxt;
        logic [MW-1:0] r_match;
        logic [MW-1:0] w_match_nxt;
        logic [SW-1:0] r_slip;
        logic [SW-1:0] w_slip_nxt;
        logic          r_bitslip;
        logic [W-1:0]  w_word;

        // Polarity correction happens before both the compare and the output register.
        assign w_word = rxd[gl*W +: W] ^ {W{INV_MASK[gl]}};
        assign w_corr[gl*W +: W] = w_word;

        always_comb begin
            w_next      = r_state;
            w_wait_nxt  = r_wait;
            w_match_nxt = r_match;
            w_slip_nxt  = r_slip;
            // Losing the PLL overrides everything, including a simultaneous start.
            if (!rx_locked[CAM]) begin
                w_next      = S_IDLE;
                w_wait_nxt  = '0;
                w_match_nxt = '0;
                w_slip_nxt  = '0;
            end else if (start) begin
                w_next      = S_SETTLE;
                w_wait_nxt  = WAIT_LOAD;
                w_match_nxt = '0;
                w_slip_nxt  = '0;
            end else begin
                case (r_state)
                    S_SETTLE: begin
                        if (r_wait <= WAIT_ONE) begin
                            w_next      = S_CHECK;
                            w_wait_nxt  = '0;
                            w_match_nxt = '0;
                        end else begin
                            w_wait_nxt = r_wait - WAIT_ONE;
                        end
                    end
                    S_CHECK: begin
                        if (w_word == TRAIN) begin
                            w_match_nxt = r_match + MATCH_ONE;
                            if (r_match == MATCH_LAST) begin
                                w_next = S_LOCKED;
                            end else begin
                                w_next = S_CHECK;
                            end
                        end else if (r_slip < SLIP_LAST) begin
                            w_next = S_SLIP;
                        end else begin
                            w_next = S_FAIL;
                        end
                    end
                    S_SLIP: begin
                        w_next      = S_SETTLE;
                        w_wait_nxt  = WAIT_LOAD;
                        w_match_nxt = '0;
                        w_slip_nxt  = r_slip + SLIP_ONE;
                    end
                    default: begin
                        w_next = r_state;
                    end
                endcase
            end
        end

        always_ff @(posedge c or posedge rst) begin
            if (rst) begin
                r_state   <= S_IDLE;
                r_wait    <= '0;
                r_match   <= '0;
                r_slip    <= '0;
                r_bitslip <= 1'b0;
            end else begin
                r_state   <= w_next;
                r_wait    <= w_wait_nxt;
                r_match   <= w_match_nxt;
                r_slip    <= w_slip_nxt;
                r_bitslip <= (w_next == S_SLIP);
            end
        end

        assign w_lane_slip[gl]   = r_bitslip;
        assign w_lane_locked[gl] = (r_state == S_LOCKED);
        assign w_lane_fail[gl]   = (r_state == S_FAIL);
        assign w_lane_busy[gl]   = (r_state == S_SETTLE) || (r_state == S_CHECK) ||
                                   (r_state == S_SLIP);
    end

    always_comb begin
        w_cam_locked = '0;
        w_cam_fail   = '0;
        for (int i = 0; i < NUM_CAMS; i++) begin
            w_cam_locked[i] = &w_lane_locked[i*LANES +: LANES];
            w_cam_fail[i]   = |w_lane_fail[i*LANES +: LANES];
        end
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_rxd_out    <= '0;
            r_cam_locked <= '0;
            r_cam_fail   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_rxd_out    <= w_corr;
            r_cam_locked <= w_cam_locked;
            r_cam_fail   <= w_cam_fail;
            r_busy       <= |w_lane_busy;
        end
    end

    assign bitslip    = w_lane_slip;
    assign rxd_out    = r_rxd_out;
    assign cam_locked = r_cam_locked;
    assign cam_fail   = r_cam_fail;
    assign busy       = r_busy;
endmodule

// File: tb/tb_cam_lane_align.sv
// Bench for cam_lane_align: a deserialiser channel model that rotates on bitslip, an
// arithmetic timeline of expected events, a scenario table and hand-written corner cases.
module tb_cam_lane_align;
    localparam int NL = 10;
    localparam logic [NL-1:0] INV = 10'h260;
    localparam logic [7:0] TR = 8'h3A;

    logic          c = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    rx_locked = 2'b11;
    logic [79:0]   rxd = '0;
    logic [NL-1:0] bitslip;
    logic [79:0]   rxd_out;
    logic [1:0]    cam_locked;
    logic [1:0]    cam_fail;
    logic          busy;

    cam_lane_align #(
        .NUM_CAMS(2), .LANES(5), .W(8), .TRAIN(8'h3A),
        .MATCH_COUNT(16), .SLIP_WAIT(4), .INV_MASK(INV)
    ) dut (
        .c(c), .rst(rst), .start(start), .rx_locked(rx_locked), .rxd(rxd),
        .bitslip(bitslip), .rxd_out(rxd_out), .cam_locked(cam_locked),
        .cam_fail(cam_fail), .busy(busy)
    );

    always #5 c = ~c;

    typedef struct {
        logic [39:0] codes;
        logic [1:0]  exp_locked;
        logic [1:0]  exp_fail;
        int          exp_pulses;
    } vec_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  base [NL];
    int          slips [NL];
    logic [79:0] cur_corr;

    task automatic chk(input string name, input int t, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, t, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] x, input int n);
        logic [7:0] r = x;
        for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
        return r;
    endfunction

    // Codes 0..7: training word rotated by that many bits; 8..10: words that never align.
    function automatic logic [7:0] code_word(input int code);
        if (code < 8) return rotl(TR, code);
        else if (code == 8) return 8'h00;
        else if (code == 9) return 8'h55;
        else return 8'hFF;
    endfunction

    task automatic drive();
        logic [7:0] w;
        for (int l = 0; l < NL; l++) begin
            w = rotr(base[l], slips[l] % 8);
            cur_corr[l*8 +: 8] = w;
            rxd[l*8 +: 8] = w ^ {8{INV[l]}};
        end
    endtask

    task automatic chan_step();
        for (int l = 0; l < NL; l++) if (bitslip[l]) slips[l]++;
        drive();
    endtask

    task automatic load(input logic [39:0] codes);
        for (int l = 0; l < NL; l++) begin
            base[l]  = code_word(int'(codes[l*4 +: 4]));
            slips[l] = 0;
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        rx_locked = 2'b11;
        @(negedge c);
        chk("reset_outputs", 0, {bitslip, cam_locked, cam_fail, busy}, 80'h0);
        chk("reset_rxd_out", 0, rxd_out, 80'h0);
        @(negedge c);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge c);
            chk("post_reset_quiet", i, {bitslip, cam_locked, cam_fail, busy}, 80'h0);
        end
        chk("post_reset_rxd_out", 0, rxd_out, cur_corr);
    endtask

    // Expected behaviour follows from the timeline: start in cycle 0, first compare in
    // cycle 5, one attempt every 6 cycles, 16 matches then LOCKED, 7 slips then FAIL.
    task automatic run_scenario(input logic [39:0] codes, output int pulses, output int exp_pulses,
                                output logic [1:0] fin_locked, output logic [1:0] fin_fail,
                                output logic [1:0] mdl_locked, output logic [1:0] mdl_fail);
        int nsl [NL];
        int dd [NL];
        bit dead [NL];
        logic [NL-1:0] e_bs;
        logic [1:0] e_lk;
        logic [1:0] e_fl;
        logic e_busy;
        load(codes);
        do_reset();
        exp_pulses = 0;
        for (int l = 0; l < NL; l++) begin
            dead[l] = (codes[l*4 +: 4] >= 4'd8);
            nsl[l]  = dead[l] ? 7 : int'(codes[l*4 +: 4]);
            dd[l]   = dead[l] ? 48 : 21 + 6 * nsl[l];
            exp_pulses += nsl[l];
        end
        pulses = 0;
        for (int t = 0; t <= 70; t++) begin
            @(negedge c);
            e_lk = 2'b11;
            e_fl = 2'b00;
            e_busy = 1'b0;
            for (int l = 0; l < NL; l++) begin
                e_bs[l] = (t >= 6) && ((t - 6) % 6 == 0) && ((t - 6) / 6 < nsl[l]);
                if ((t - 1 >= 1) && (t - 1 < dd[l])) e_busy = 1'b1;
                if (dead[l] || (t - 1 < dd[l])) e_lk[l / 5] = 1'b0;
                if (dead[l] && (t - 1 >= dd[l])) e_fl[l / 5] = 1'b1;
            end
            chk("bitslip", t, 80'(bitslip), 80'(e_bs));
            chk("cam_locked", t, 80'(cam_locked), 80'(e_lk));
            chk("cam_fail", t, 80'(cam_fail), 80'(e_fl));
            chk("busy", t, 80'(busy), 80'(e_busy));
            chk("rxd_out", t, rxd_out, cur_corr);
            pulses += $countones(bitslip);
            start = (t == 0);
            chan_step();
        end
        fin_locked = cam_locked;
        fin_fail = cam_fail;
        mdl_locked = 2'b11;
        mdl_fail = 2'b00;
        for (int l = 0; l < NL; l++) begin
            if (dead[l]) begin
                mdl_locked[l / 5] = 1'b0;
                mdl_fail[l / 5] = 1'b1;
            end
        end
    endtask

    initial begin
        vec_t tbl [4];
        int pulses, mpulses;
        logic [1:0] fl, ff, ml, mf;
        logic [39:0] rc;

        tbl[0] = '{codes: 40'h0000000000, exp_locked: 2'b11, exp_fail: 2'b00, exp_pulses: 0};
        tbl[1] = '{codes: 40'h0000000300, exp_locked: 2'b11, exp_fail: 2'b00, exp_pulses: 3};
        tbl[2] = '{codes: 40'h8888800000, exp_locked: 2'b01, exp_fail: 2'b10, exp_pulses: 35};
        tbl[3] = '{codes: 40'h0200970000, exp_locked: 2'b01, exp_fail: 2'b10, exp_pulses: 16};

        for (int v = 0; v < 4; v++) begin
            run_scenario(tbl[v].codes, pulses, mpulses, fl, ff, ml, mf);
            chk("tbl_pulses", v, 80'(pulses), 80'(tbl[v].exp_pulses));
            chk("tbl_final_locked", v, 80'(fl), 80'(tbl[v].exp_locked));
            chk("tbl_final_fail", v, 80'(ff), 80'(tbl[v].exp_fail));
        end

        // Inverted cam 1 lanes receive the complement and must come out as the training word.
        load(40'h0);
        chk("inv_raw_drive", 0, 80'(rxd[5*8 +: 8]), 80'(8'hC5));
        @(negedge c);
        @(negedge c);
        chk("inv_rxd_out", 0, 80'({rxd_out[9*8 +: 8], rxd_out[6*8 +: 8], rxd_out[5*8 +: 8]}),
            80'(24'h3A3A3A));

        for (int r = 0; r < 6; r++) begin
            rc = '0;
            for (int l = 0; l < NL; l++) begin
                if ($urandom_range(0, 5) == 0) rc[l*4 +: 4] = 4'(8 + $urandom_range(0, 2));
                else rc[l*4 +: 4] = 4'($urandom_range(0, 7));
            end
            run_scenario(rc, pulses, mpulses, fl, ff, ml, mf);
            chk("rnd_pulses", r, 80'(pulses), 80'(mpulses));
            chk("rnd_final_locked", r, 80'(fl), 80'(ml));
            chk("rnd_final_fail", r, 80'(ff), 80'(mf));
        end

        // Cam 0 PLL drops in the CHECK cycle that would have led to a slip.
        load(40'h0000000001);
        do_reset();
        for (int t = 0; t <= 40; t++) begin
            @(negedge c);
            if (t >= 6) chk("drop_cam0_quiet", t, 80'({bitslip, cam_locked[0], cam_fail[0]}), 80'h0);
            if (t == 22) chk("drop_cam1_lock", t, 80'({cam_locked, busy}), 80'(3'b100));
            start = (t == 0);
            if (t == 5) rx_locked = 2'b10;
            chan_step();
        end
        // Start while cam 0 PLL is still down: cam 0 stays idle, cam 1 realigns.
        for (int t = 0; t <= 40; t++) begin
            @(negedge c);
            if (t >= 1) chk("start_cam0_down", t, 80'({bitslip[4:0], cam_locked[0], cam_fail[0]}), 80'h0);
            if (t == 2) chk("restart_unlock", t, 80'(cam_locked), 80'(2'b00));
            if (t == 22) chk("restart_relock", t, 80'({cam_locked, busy}), 80'(3'b100));
            start = (t == 0);
            chan_step();
        end
        // Start in the same cycle cam 1 PLL drops: cam 1 idles, cam 0 aligns with one slip.
        for (int t = 0; t <= 40; t++) begin
            @(negedge c);
            if (t >= 2) chk("same_cycle_cam1", t, 80'({bitslip[9:5], cam_locked[1], cam_fail[1]}), 80'h0);
            if (t == 6) chk("same_cycle_slip", t, 80'(bitslip), 80'(10'h001));
            if (t == 27) chk("same_cycle_prelock", t, 80'(cam_locked), 80'(2'b00));
            if (t == 28) chk("same_cycle_lock", t, 80'({cam_locked, busy}), 80'(3'b010));
            start = (t == 0);
            if (t == 0) rx_locked = 2'b01;
            chan_step();
        end

        // Reset asserted while a slip pulse is on the output.
        load(40'h0000000300);
        do_reset();
        for (int t = 0; t <= 6; t++) begin
            @(negedge c);
            start = (t == 0);
            if (t < 6) chan_step();
        end
        chk("slip_before_rst", 6, 80'(bitslip), 80'(10'h004));
        rst = 1'b1;
        #1;
        chk("rst_during_slip", 6, 80'({bitslip, cam_locked, cam_fail, busy}), 80'h0);
        @(negedge c);
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge c);
            chk("idle_after_rst", t, 80'({bitslip, cam_locked, cam_fail, busy}), 80'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
